lab3_sweep_ctrl: RTL

- Self-test sequencer for the team's 3-input / 2-output combinational logic block (inputs a, b, c; outputs x, y).
- On start, drives all 8 input vectors 000..111 in ascending order and holds each vector for HOLD_CYCLES clocks.
- Samples x/y at the end of each hold, compares them against a parameterised truth table, and reports mismatch count, first failing vector and pass/fail.
- Sits between the block under check and board-level controls (button for start, LEDs for results).

---
 rtl/lab3_sweep_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/lab3_sweep_ctrl.sv
// Self-test sequencer for the 3-in/2-out logic block: steps {a,b,c} through 000..111,
// samples x/y at the end of each hold window and accumulates mismatch results.
module lab3_sweep_ctrl #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [7:0]  EXP_X       = 8'b1110_1000,
    parameter logic [7:0]  EXP_Y       = 8'b1001_0110
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output logic       a_o,
    output logic       b_o,
    output logic       c_o,
    input  logic       x_i,
    input  logic       y_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail_vec,
    output logic       first_fail_valid,
    output logic [2:0] vec_idx,
    output logic [1:0] dbg_state_o
);

    // Control protocol: start/abort are plain levels sampled every rising edge.
    // start only matters outside a sweep; abort always beats start.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state_q;
    logic [7:0] hold_q;
    logic [2:0] vec_q;
    logic [2:0] drive_q;
    logic [2:0] ffvec_q;
    logic [3:0] err_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic       ffv_q;

    logic       sample_pt;
    logic       vec_err;
    logic       launch;
    logic [3:0] err_d;
    logic [2:0] vec_d;

    assign sample_pt = (hold_q == HOLD_LAST);
    assign vec_err   = (x_i != EXP_X[vec_q]) || (y_i != EXP_Y[vec_q]);
    // One count per vector, even when x and y both disagree.
    assign err_d     = err_q + {3'b000, vec_err};
    assign vec_d     = vec_q + 3'd1;
    assign launch    = start && !abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            hold_q  <= 8'd0;
            vec_q   <= 3'd0;
            drive_q <= 3'd0;
            ffvec_q <= 3'd0;
            err_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            ffv_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (abort) begin
                        done_q <= 1'b0;
                        pass_q <= 1'b0;
                    end else if (launch) begin
                        state_q <= S_DRIVE;
                        hold_q  <= 8'd0;
                        vec_q   <= 3'd0;
                        drive_q <= 3'd0;
                        ffvec_q <= 3'd0;
                        err_q   <= 4'd0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        ffv_q   <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (abort) begin
                        // Results and vec_idx stay put so the aborted point can be inspected.
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        drive_q <= 3'd0;
                    end else if (sample_pt) begin
                        err_q <= err_d;
                        if (vec_err && !ffv_q) begin
                            ffvec_q <= vec_q;
                            ffv_q   <= 1'b1;
                        end
                        if (vec_q == 3'd7) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == 4'd0);
                            drive_q <= 3'd0;
                        end else begin
                            vec_q   <= vec_d;
                            drive_q <= vec_d;
                            hold_q  <= 8'd0;
                        end
                    end else begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                    drive_q <= 3'd0;
                end
            endcase
        end
    end

    assign a_o              = drive_q[2];
    assign b_o              = drive_q[1];
    assign c_o              = drive_q[0];
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ffvec_q;
    assign first_fail_valid = ffv_q;
    assign vec_idx          = vec_q;
    assign dbg_state_o      = state_q;

endmodule
